// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive path: receiver FSM
//                state encoding, data width and default baud divider.
//                The PARITY state exists only when UART_RX_PARITY_EN is
//                defined (8E1 framing); otherwise the frame is 8N1.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int UART_DEFAULT_BAUD_DIV = 347;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY    = 3'd5
`endif
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync_fifo
//  Description : Parameterised single-clock FIFO. Pointers are one bit wider
//                than the address so full/empty fall out of a plain compare.
//                A push while full is accepted only when a pop happens in the
//                same cycle; a pop while empty is ignored.
//  Ports       : clk, rst_n (async, active-low)
//                push_i/data_i  - write side
//                pop_i/data_o   - read side, data_o is the head entry
//                full_o, empty_o, level_o - status
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= data_i;
        wptr_q                <= wptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receive front end. Synchronises rx_i, deserialises
//                8N1 frames (8E1 when UART_RX_PARITY_EN is defined), checks
//                framing and buffers good bytes in a small FIFO presented
//                through a valid/ready handshake.
//  Ports       : clk, rst_n (async, active-low), rx_i (serial, idles high)
//                rx_data_o/rx_valid_o/rx_ready_i - FIFO head handshake
//                frame_err_o, overrun_o - sticky flags, cleared by err_clr_i
//                busy_o - receiver not idle; rx_level_o - FIFO occupancy
//  Macros      : UART_RX_PARITY_EN - enable even parity bit (8E1)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  output logic [UART_DATA_W-1:0]        rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  input  logic                          err_clr_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level_o
);

  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] BIT_RELOAD  = 16'(BAUD_DIV - 1);

  logic [1:0]             sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;
  rx_state_e              state_q;
  logic [15:0]            cnt_q;
  logic [2:0]             bit_idx_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   busy_q;
  logic                   tick;
  logic                   stop_tick;
  logic                   stop_ok;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   ferr_set;
  logic                   ovr_set;
`ifdef UART_RX_PARITY_EN
  logic                   par_q;     // running XOR of data and parity bits
`endif

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
    end
  end
  assign rx_s = sync_q[1];

  assign tick      = (cnt_q == 16'd0);
  assign stop_tick = (state_q == ST_STOP) && tick;
`ifdef UART_RX_PARITY_EN
  assign stop_ok   = rx_s && !par_q;
`else
  assign stop_ok   = rx_s;
`endif
  assign push      = stop_tick && stop_ok;
  assign ferr_set  = stop_tick && !stop_ok;
  assign pop       = rx_valid_o && rx_ready_i;
  // The FIFO drops a push when full unless the head is leaving this cycle.
  assign ovr_set   = push && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            cnt_q   <= HALF_RELOAD;
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state_q <= ST_IDLE;   // glitch shorter than half a bit
              busy_q  <= 1'b0;
            end else begin
              cnt_q     <= BIT_RELOAD;
              bit_idx_q <= 3'd0;
              state_q   <= ST_DATA;
`ifdef UART_RX_PARITY_EN
              par_q     <= 1'b0;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q   <= {rx_s, shift_q[UART_DATA_W-1:1]};
            cnt_q     <= BIT_RELOAD;
            bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_q ^ rx_s;
            if (bit_idx_q == 3'd7) state_q <= ST_PARITY;
`else
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
`endif
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            par_q   <= par_q ^ rx_s;
            cnt_q   <= BIT_RELOAD;
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            // A low stop bit may be a break: wait for the line to recover.
            if (!rx_s) begin
              state_q <= ST_WAIT_IDLE;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Set wins over a simultaneous clear.
      if (ferr_set)       frame_err_q <= 1'b1;
      else if (err_clr_i) frame_err_q <= 1'b0;
      if (ovr_set)        overrun_q   <= 1'b1;
      else if (err_clr_i) overrun_q   <= 1'b0;
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (rx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (rx_level_o)
  );

  assign rx_valid_o  = !fifo_empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A queue-based model
//                predicts FIFO contents, flags and busy from frame start
//                times and the documented receive latency; a compare process
//                checks every cycle. Literal checks pin latency and data.
//                Build with UART_RX_PARITY_EN defined to cover 8E1 framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int B     = 32;
  localparam int H     = B / 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
  localparam int LAT     = 3 + H + 10 * B;
  localparam int LAT_LIT = 339;
`else
  localparam int LAT     = 3 + H + 9 * B;
  localparam int LAT_LIT = 307;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx_i = 1'b1;
  logic          rx_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic [7:0]    rx_data_o;
  logic          rx_valid_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          busy_o;
  logic [LW-1:0] rx_level_o;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .err_clr_i   (err_clr),
    .busy_o      (busy_o),
    .rx_level_o  (rx_level_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Behavioural model state
  logic [7:0] q[$];
  bit         m_ferr, m_ovr, m_busy;
  logic [7:0] ev_push[int];
  bit         ev_ferr[int];
  bit         ev_busy[int];
  int         rise_cyc = -1, fall_cyc = -1;
  logic [7:0] rise_data = 8'h00;
  logic       prev_valid = 1'b0;

  task automatic model_reset();
    q.delete();
    m_ferr = 0; m_ovr = 0; m_busy = 0;
    ev_push.delete(); ev_ferr.delete(); ev_busy.delete();
  endtask

  // Model advances once per rising edge using inputs as the DUT saw them.
  always @(posedge clk) begin
    bit pop_now, set_ovr, set_ferr;
    cyc++;
    if (rst_n) begin
      pop_now  = (q.size() != 0) && rx_ready;
      set_ovr  = 0;
      set_ferr = ev_ferr.exists(cyc);
      if (pop_now) void'(q.pop_front());
      if (ev_push.exists(cyc)) begin
        if (q.size() == DEPTH) set_ovr = 1;
        else q.push_back(ev_push[cyc]);
      end
      if (set_ovr) m_ovr = 1; else if (err_clr) m_ovr = 0;
      if (set_ferr) m_ferr = 1; else if (err_clr) m_ferr = 0;
      if (ev_busy.exists(cyc)) m_busy = ev_busy[cyc];
      ev_push.delete(cyc); ev_ferr.delete(cyc); ev_busy.delete(cyc);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0]    exp_d;
      logic [LW-1:0] exp_l;
      bit            ok;
      exp_d = (q.size() != 0) ? q[0] : 8'h00;
      exp_l = LW'(q.size());
      vectors++;
      ok = (rx_valid_o === (q.size() != 0)) && (rx_level_o === exp_l) &&
           (frame_err_o === m_ferr) && (overrun_o === m_ovr) && (busy_o === m_busy);
      if (q.size() != 0 && rx_data_o !== exp_d) ok = 0;
      if (!ok) begin
        miscompares++;
        $display("FAIL model cyc=%0d: got valid=%b lvl=%0d data=%h ferr=%b ovr=%b busy=%b, want valid=%b lvl=%0d data=%h ferr=%b ovr=%b busy=%b",
                 cyc, rx_valid_o, rx_level_o, rx_data_o, frame_err_o, overrun_o, busy_o,
                 q.size() != 0, exp_l, exp_d, m_ferr, m_ovr, m_busy);
      end
      if (rx_valid_o && !prev_valid) begin rise_cyc = cyc; rise_data = rx_data_o; end
      if (!rx_valid_o && prev_valid) fall_cyc = cyc;
      prev_valid = rx_valid_o;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic v);
    rx_i = v;
    repeat (B) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; p is that edge's cycle number.
  task automatic send(input logic [7:0] b, input bit stop_v, input bit par_bad,
                      input int hold, output int p);
    p = cyc;
    ev_busy[p + 3] = 1;
    if (stop_v && !par_bad) begin
      ev_push[p + LAT] = b;
      ev_busy[p + LAT] = 0;
    end else begin
      ev_ferr[p + LAT] = 1;
      if (stop_v) ev_busy[p + LAT] = 0;
    end
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^b) ^ par_bad);
`endif
    bit_time(stop_v);
    if (!stop_v) begin
      repeat (hold) bit_time(1'b0);
      rx_i = 1'b1;
      ev_busy[cyc + 3] = 0;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  initial begin
    int p;
    logic [7:0] seq [5];
    bit done;
    seq[0] = 8'h3E; seq[1] = 8'h44; seq[2] = 8'h4A; seq[3] = 8'h50; seq[4] = 8'hAB;
    done = 0;

    // Reset and idle line
    #1 rst_n = 1'b0;
    model_reset();
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", rx_data_o, 8'h00);
    check("reset_valid", rx_valid_o, 0);
    rst_n = 1'b1;
    idle(20 * B);
    check("idle_busy", busy_o, 0);
    check("idle_level", rx_level_o, 0);
    check("idle_flags", {frame_err_o, overrun_o}, 0);

    // Single byte with ready high: latency and one-cycle valid pulse
    rx_ready = 1'b1;
    send(8'h1E, 1, 0, 0, p);
    idle(B);
    check("latency", rise_cyc - p, LAT_LIT);
    check("pulse_width", fall_cyc - rise_cyc, 1);
    check("data_1e", rise_data, 8'h1E);
    check("no_flags", {frame_err_o, overrun_o}, 0);

    // Fill past depth with ready low
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(seq[i], 1, 0, 0, p);
    idle(4);
    check("full_level", rx_level_o, 4);
    check("overrun", overrun_o, 1);
    for (int i = 0; i < 4; i++) begin
      check("pop_order", rx_data_o, seq[i]);
      rx_ready = 1'b1;
      idle(1);
      rx_ready = 1'b0;
    end
    check("drained", rx_level_o, 0);
    pulse_clr();
    check("ovr_cleared", overrun_o, 0);

    // Low stop bit followed by a break, then a good byte
    send(8'h55, 0, 0, 3, p);
    idle(4);
    check("frame_err", frame_err_o, 1);
    check("no_push_on_ferr", rx_level_o, 0);
    send(8'h0A, 1, 0, 0, p);
    idle(2);
    check("after_break", rx_data_o, 8'h0A);
    check("after_break_lvl", rx_level_o, 1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    pulse_clr();
    check("ferr_cleared", frame_err_o, 0);

    // False start: 0.3-bit glitch
    p = cyc;
    ev_busy[p + 3] = 1;
    ev_busy[p + 3 + H] = 0;
    rx_i = 1'b0;
    idle(B * 3 / 10);
    rx_i = 1'b1;
    idle(2 * B);
    check("glitch_level", rx_level_o, 0);
    check("glitch_busy", busy_o, 0);
    check("glitch_flags", {frame_err_o, overrun_o}, 0);

    // Reset during bit 4 of 0xFF with one byte already queued
    send(8'h5A, 1, 0, 0, p);
    idle(2);
    check("preload_lvl", rx_level_o, 1);
    p = cyc;
    ev_busy[p + 3] = 1;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    idle(B / 2);
    rst_n = 1'b0;
    rx_i = 1'b1;
    model_reset();
    #1;
    check("rst_level", rx_level_o, 0);
    check("rst_busy", busy_o, 0);
    idle(2);
    rst_n = 1'b1;
    idle(B);
    send(8'h01, 1, 0, 0, p);
    idle(2);
    check("post_rst_data", rx_data_o, 8'h01);
    check("post_rst_lvl", rx_level_o, 1);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
    // Bad parity with good stop bit
    send(8'hC3, 1, 1, 0, p);
    idle(4);
    check("parity_ferr", frame_err_o, 1);
    check("parity_no_push", rx_level_o, 0);
    pulse_clr();
`endif

    // Randomised traffic with sparse pops and occasional framing faults
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [7:0] b;
          bit bad;
          int pp;
          b   = 8'($urandom);
          bad = ($urandom_range(0, 7) == 0);
          send(b, !bad, 0, bad ? int'($urandom_range(0, 2)) : 0, pp);
          idle($urandom_range(0, B));
        end
        done = 1;
      end
      begin
        while (!done) begin
          rx_ready = ($urandom_range(0, 511) == 0);
          err_clr  = ($urandom_range(0, 999) == 0);
          idle(1);
        end
        rx_ready = 1'b0;
        err_clr  = 1'b0;
      end
    join

    rx_ready = 1'b1;
    idle(8);
    check("final_drain", rx_level_o, 0);
    rx_ready = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
